// File: rtl/vi_pkg.sv
// Shared VI marker definitions: frame length, index width and the
// receiver lock state encoding (also used by the VI transmitter).
package vi_pkg;

  localparam int PULSES_DEF = 39;
  localparam int IDX_W      = 6;

  typedef enum logic {
    SEARCH = 1'b0,
    TRACK  = 1'b1
  } vi_state_e;

endpackage

// File: rtl/vi_edge_sync.sv
// Brings the asynchronous VI line into the clk domain and produces
// registered rise/fall strobes aligned with the synced line level.
module vi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic line,
  output logic rise,
  output logic fall
);

  // [0],[1] form the 2-FF synchronizer; [2] is the edge-detect history
  logic [2:0] sync_reg;
  logic       rise_reg;
  logic       fall_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_reg <= '0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[1:0], din};
      rise_reg <= sync_reg[1] & ~sync_reg[2];
      fall_reg <= ~sync_reg[1] & sync_reg[2];
    end
  end

  assign line = sync_reg[2];
  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/vi_frame_sync.sv
// VI marker receiver: measures high/low phase widths, finds the suppressed
// pulse (gap), indexes pulses within the frame and tracks frame lock.
module vi_frame_sync
  import vi_pkg::*;
#(
  parameter int PULSES      = PULSES_DEF,
  parameter int CNT_W       = 10,
  parameter int LOCK_FRAMES = 2,
  parameter int IDLE_MAX    = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iVI,
  output logic             oPulse,
  output logic [IDX_W-1:0] oIdx,
  output logic             oFrame,
  output logic             oLocked,
  output logic             oErr
);

  localparam int IDLE_W = $clog2(IDLE_MAX);
  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(PULSES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_MAX - 1);
  localparam logic [GOOD_W-1:0] GOOD_FINAL = GOOD_W'(LOCK_FRAMES - 1);

  logic line;
  logic rise;
  logic fall;

  vi_state_e         state_reg, state_next;
  logic [CNT_W-1:0]  hi_cnt_reg, hi_cnt_next;
  logic [CNT_W-1:0]  lo_cnt_reg, lo_cnt_next;
  logic [CNT_W-1:0]  hi_width_reg, hi_width_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [GOOD_W-1:0] good_cnt_reg, good_cnt_next;
  logic              aligned_reg, aligned_next;
  logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
  logic              idle_armed_reg, idle_armed_next;
  logic              pulse_reg, pulse_next;
  logic              frame_reg, frame_next;
  logic              err_reg, err_next;

  logic gap;
  logic idle_hit;
  logic frame_good;

  vi_edge_sync u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (iVI),
    .line (line),
    .rise (rise),
    .fall (fall)
  );

  // Compare one bit wider so 2*hi_width cannot overflow
  assign gap        = (hi_width_reg != '0) &&
                      ({1'b0, lo_cnt_reg} > {hi_width_reg, 1'b0});
  assign frame_good = (idx_reg == IDX_LAST);
  assign idle_hit   = idle_armed_reg && !rise && !fall &&
                      (idle_cnt_reg == IDLE_LAST);

  // Phase width counters, saturating
  always_comb begin
    hi_cnt_next   = hi_cnt_reg;
    lo_cnt_next   = lo_cnt_reg;
    hi_width_next = hi_width_reg;

    if (rise) begin
      hi_cnt_next = CNT_W'(1);
    end else if (line && (hi_cnt_reg != CNT_MAX)) begin
      hi_cnt_next = hi_cnt_reg + 1'b1;
    end

    if (rise) begin
      lo_cnt_next = '0;
    end else if (fall) begin
      lo_cnt_next = CNT_W'(1);
    end else if (!line && (lo_cnt_reg != CNT_MAX)) begin
      lo_cnt_next = lo_cnt_reg + 1'b1;
    end

    if (idle_hit) begin
      hi_width_next = '0;
    end else if (fall) begin
      hi_width_next = hi_cnt_reg;
    end
  end

  // Loss-of-signal timer: fires once per quiet stretch, re-armed by any edge
  always_comb begin
    idle_cnt_next   = idle_cnt_reg;
    idle_armed_next = idle_armed_reg;
    if (rise || fall) begin
      idle_cnt_next   = '0;
      idle_armed_next = 1'b1;
    end else if (idle_hit) begin
      idle_armed_next = 1'b0;
    end else if (idle_armed_reg) begin
      idle_cnt_next = idle_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    good_cnt_next = good_cnt_reg;
    aligned_next  = aligned_reg;
    pulse_next    = rise;
    frame_next    = 1'b0;
    err_next      = 1'b0;

    if (idle_hit) begin
      state_next    = SEARCH;
      good_cnt_next = '0;
      aligned_next  = 1'b0;
      err_next      = (state_reg == TRACK);
    end else if (rise && gap) begin
      idx_next     = '0;
      frame_next   = 1'b1;
      aligned_next = 1'b1;
      // A bad gap still realigns the index, so the next gap is checked
      if (aligned_reg) begin
        if (frame_good) begin
          if (state_reg == SEARCH) begin
            good_cnt_next = good_cnt_reg + 1'b1;
            if (good_cnt_reg == GOOD_FINAL) begin
              state_next = TRACK;
            end
          end
        end else begin
          good_cnt_next = '0;
          if (state_reg == TRACK) begin
            err_next   = 1'b1;
            state_next = SEARCH;
          end
        end
      end
    end else if (rise) begin
      if (idx_reg == IDX_LAST) begin
        good_cnt_next = '0;
        if (state_reg == TRACK) begin
          err_next     = 1'b1;
          state_next   = SEARCH;
          aligned_next = 1'b0;
        end
      end else begin
        idx_next = idx_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= SEARCH;
      hi_cnt_reg     <= '0;
      lo_cnt_reg     <= '0;
      hi_width_reg   <= '0;
      idx_reg        <= '0;
      good_cnt_reg   <= '0;
      aligned_reg    <= 1'b0;
      idle_cnt_reg   <= '0;
      idle_armed_reg <= 1'b1;
      pulse_reg      <= 1'b0;
      frame_reg      <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hi_cnt_reg     <= hi_cnt_next;
      lo_cnt_reg     <= lo_cnt_next;
      hi_width_reg   <= hi_width_next;
      idx_reg        <= idx_next;
      good_cnt_reg   <= good_cnt_next;
      aligned_reg    <= aligned_next;
      idle_cnt_reg   <= idle_cnt_next;
      idle_armed_reg <= idle_armed_next;
      pulse_reg      <= pulse_next;
      frame_reg      <= frame_next;
      err_reg        <= err_next;
    end
  end

  assign oPulse  = pulse_reg;
  assign oIdx    = idx_reg;
  assign oFrame  = frame_reg;
  assign oErr    = err_reg;
  assign oLocked = (state_reg == TRACK);

endmodule

// File: tb/tb_vi_frame_sync.sv
// Directed bench for vi_frame_sync: clean stream, short/long frames, idle loss,
// jitter and mid-frame reset, with hand-computed expectations.
module tb_vi_frame_sync;

  logic       clk;
  logic       rst;
  logic       iVI;
  logic       oPulse;
  logic [5:0] oIdx;
  logic       oFrame;
  logic       oLocked;
  logic       oErr;

  int n_checks;
  int n_pass;

  typedef struct {
    int idx;
    bit pulse;
    bit frame;
    bit err;
    bit locked;
  } ev_t;

  ev_t evq[$];
  ev_t ev_log;
  int  fidx[$];
  int  n_ev;
  int  n_frame_ev;
  int  n_err_ev;

  vi_frame_sync dut (
    .clk     (clk),
    .rst     (rst),
    .iVI     (iVI),
    .oPulse  (oPulse),
    .oIdx    (oIdx),
    .oFrame  (oFrame),
    .oLocked (oLocked),
    .oErr    (oErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every strobe cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (rst && (oPulse || oFrame || oErr)) begin
      ev_log.idx    = int'(oIdx);
      ev_log.pulse  = oPulse;
      ev_log.frame  = oFrame;
      ev_log.err    = oErr;
      ev_log.locked = oLocked;
      evq.push_back(ev_log);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    iVI = 1'b1;
    cyc(hi);
    iVI = 1'b0;
    cyc(lo);
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n - 1; i++) pulse(8, 8);
    pulse(8, 24);
  endtask

  task automatic send_jitter_frame();
    for (int i = 0; i < 38; i++) pulse(8, 6 + (i % 5));
    pulse(8, 24);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    iVI = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(2);
  endtask

  // Summarise the log; pads queues so fixed-index reads stay in range
  task automatic scan();
    ev_t pad;
    fidx.delete();
    n_err_ev = 0;
    n_ev     = evq.size();
    foreach (evq[i]) begin
      if (evq[i].frame) fidx.push_back(i);
      if (evq[i].err) n_err_ev++;
    end
    n_frame_ev = fidx.size();
    while (fidx.size() < 8) fidx.push_back(0);
    pad.idx = -1; pad.pulse = 0; pad.frame = 0; pad.err = 0; pad.locked = 0;
    while (evq.size() < 300) evq.push_back(pad);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    iVI = 1'b0;
    cyc(3);
    n_checks++; if (oPulse !== 1'b0) $display("FAIL reset_pulse: got %0b expected 0", oPulse); else begin n_pass++; $display("check reset_pulse ok"); end
    n_checks++; if (oIdx !== 6'd0) $display("FAIL reset_idx: got %0d expected 0", oIdx); else begin n_pass++; $display("check reset_idx ok"); end
    n_checks++; if (oFrame !== 1'b0) $display("FAIL reset_frame: got %0b expected 0", oFrame); else begin n_pass++; $display("check reset_frame ok"); end
    n_checks++; if (oLocked !== 1'b0) $display("FAIL reset_locked: got %0b expected 0", oLocked); else begin n_pass++; $display("check reset_locked ok"); end
    n_checks++; if (oErr !== 1'b0) $display("FAIL reset_err: got %0b expected 0", oErr); else begin n_pass++; $display("check reset_err ok"); end
    rst = 1'b1;
    cyc(5);
    iVI = 1'b1;
    cyc(3);
    n_checks++; if (oPulse !== 1'b0) $display("FAIL latency_early: got %0b expected 0", oPulse); else begin n_pass++; $display("check latency_early ok"); end
    cyc(1);
    n_checks++; if (oPulse !== 1'b1) $display("FAIL latency_pulse: got %0b expected 1", oPulse); else begin n_pass++; $display("check latency_pulse ok"); end
    n_checks++; if (oFrame !== 1'b0) $display("FAIL first_edge_frame: got %0b expected 0", oFrame); else begin n_pass++; $display("check first_edge_frame ok"); end
    cyc(4);
    iVI = 1'b0;
    cyc(8);
  endtask

  task automatic test_clean();
    do_reset();
    evq.delete();
    for (int f = 0; f < 5; f++) send_frame(39);
    scan();
    n_checks++; if (n_ev !== 195) $display("FAIL clean_events: got %0d expected 195", n_ev); else begin n_pass++; $display("check clean_events ok"); end
    n_checks++; if (n_frame_ev !== 4) $display("FAIL clean_frames: got %0d expected 4", n_frame_ev); else begin n_pass++; $display("check clean_frames ok"); end
    n_checks++; if (fidx[0] !== 39) $display("FAIL clean_first_frame_pos: got %0d expected 39", fidx[0]); else begin n_pass++; $display("check clean_first_frame_pos ok"); end
    n_checks++; if (evq[fidx[1]].locked !== 1'b0) $display("FAIL clean_lock_f2: got %0b expected 0", evq[fidx[1]].locked); else begin n_pass++; $display("check clean_lock_f2 ok"); end
    n_checks++; if (evq[fidx[2]].locked !== 1'b1) $display("FAIL clean_lock_f3: got %0b expected 1", evq[fidx[2]].locked); else begin n_pass++; $display("check clean_lock_f3 ok"); end
    n_checks++; if (evq[fidx[3]].locked !== 1'b1) $display("FAIL clean_lock_f4: got %0b expected 1", evq[fidx[3]].locked); else begin n_pass++; $display("check clean_lock_f4 ok"); end
    n_checks++; if (n_err_ev !== 0) $display("FAIL clean_err: got %0d expected 0", n_err_ev); else begin n_pass++; $display("check clean_err ok"); end
    for (int f = 1; f < 5; f++) begin
      int bad;
      bad = -1;
      for (int j = 0; j < 39; j++) if (bad < 0 && evq[39 * f + j].idx != j) bad = j;
      n_checks++;
      if (bad >= 0) $display("FAIL clean_idx_f%0d: got idx %0d expected %0d", f, evq[39 * f + bad].idx, bad);
      else begin n_pass++; $display("check clean_idx_f%0d ok", f); end
    end
  endtask

  task automatic test_short_frame();
    evq.delete();
    send_frame(38);
    for (int f = 0; f < 3; f++) send_frame(39);
    scan();
    n_checks++; if (n_frame_ev !== 4) $display("FAIL short_frames: got %0d expected 4", n_frame_ev); else begin n_pass++; $display("check short_frames ok"); end
    n_checks++; if (fidx[1] !== 38) $display("FAIL short_bad_pos: got %0d expected 38", fidx[1]); else begin n_pass++; $display("check short_bad_pos ok"); end
    n_checks++; if (evq[38].err !== 1'b1 || evq[38].frame !== 1'b1) $display("FAIL short_err_frame: got err %0b frame %0b expected 1 1", evq[38].err, evq[38].frame); else begin n_pass++; $display("check short_err_frame ok"); end
    n_checks++; if (evq[38].locked !== 1'b0) $display("FAIL short_unlock: got %0b expected 0", evq[38].locked); else begin n_pass++; $display("check short_unlock ok"); end
    n_checks++; if (evq[77].locked !== 1'b0) $display("FAIL short_relock_early: got %0b expected 0", evq[77].locked); else begin n_pass++; $display("check short_relock_early ok"); end
    n_checks++; if (evq[116].locked !== 1'b1 || evq[116].frame !== 1'b1) $display("FAIL short_relock: got locked %0b frame %0b expected 1 1", evq[116].locked, evq[116].frame); else begin n_pass++; $display("check short_relock ok"); end
    n_checks++; if (n_err_ev !== 1) $display("FAIL short_err_count: got %0d expected 1", n_err_ev); else begin n_pass++; $display("check short_err_count ok"); end
  endtask

  task automatic test_overflow();
    evq.delete();
    for (int i = 0; i < 40; i++) pulse(8, 8);
    pulse(8, 24);
    send_frame(39);
    scan();
    n_checks++; if (evq[38].idx !== 38 || evq[38].locked !== 1'b1) $display("FAIL ovf_last_good: got idx %0d locked %0b expected 38 1", evq[38].idx, evq[38].locked); else begin n_pass++; $display("check ovf_last_good ok"); end
    n_checks++; if (evq[39].err !== 1'b1) $display("FAIL ovf_err: got %0b expected 1", evq[39].err); else begin n_pass++; $display("check ovf_err ok"); end
    n_checks++; if (evq[39].idx !== 38) $display("FAIL ovf_idx_hold: got %0d expected 38", evq[39].idx); else begin n_pass++; $display("check ovf_idx_hold ok"); end
    n_checks++; if (evq[39].locked !== 1'b0) $display("FAIL ovf_unlock: got %0b expected 0", evq[39].locked); else begin n_pass++; $display("check ovf_unlock ok"); end
    n_checks++; if (evq[40].idx !== 38 || evq[40].err !== 1'b0) $display("FAIL ovf_search_sat: got idx %0d err %0b expected 38 0", evq[40].idx, evq[40].err); else begin n_pass++; $display("check ovf_search_sat ok"); end
    n_checks++; if (evq[41].frame !== 1'b1 || evq[41].idx !== 0) $display("FAIL ovf_realign: got frame %0b idx %0d expected 1 0", evq[41].frame, evq[41].idx); else begin n_pass++; $display("check ovf_realign ok"); end
    n_checks++; if (n_err_ev !== 1) $display("FAIL ovf_err_count: got %0d expected 1", n_err_ev); else begin n_pass++; $display("check ovf_err_count ok"); end
  endtask

  task automatic test_idle();
    send_frame(39);
    send_frame(39);
    n_checks++; if (oLocked !== 1'b1) $display("FAIL idle_prelock: got %0b expected 1", oLocked); else begin n_pass++; $display("check idle_prelock ok"); end
    evq.delete();
    cyc(1200);
    scan();
    n_checks++; if (n_err_ev !== 1) $display("FAIL idle_err_count: got %0d expected 1", n_err_ev); else begin n_pass++; $display("check idle_err_count ok"); end
    n_checks++; if (evq[0].pulse !== 1'b0) $display("FAIL idle_err_nopulse: got %0b expected 0", evq[0].pulse); else begin n_pass++; $display("check idle_err_nopulse ok"); end
    n_checks++; if (oLocked !== 1'b0) $display("FAIL idle_unlock: got %0b expected 0", oLocked); else begin n_pass++; $display("check idle_unlock ok"); end
    evq.delete();
    send_frame(39);
    send_frame(39);
    scan();
    n_checks++; if (evq[0].pulse !== 1'b1 || evq[0].frame !== 1'b0) $display("FAIL idle_resume_nogap: got pulse %0b frame %0b expected 1 0", evq[0].pulse, evq[0].frame); else begin n_pass++; $display("check idle_resume_nogap ok"); end
    n_checks++; if (n_frame_ev !== 1 || fidx[0] !== 39) $display("FAIL idle_resume_frame: got count %0d pos %0d expected 1 39", n_frame_ev, fidx[0]); else begin n_pass++; $display("check idle_resume_frame ok"); end
    n_checks++; if (n_err_ev !== 0) $display("FAIL idle_resume_err: got %0d expected 0", n_err_ev); else begin n_pass++; $display("check idle_resume_err ok"); end
  endtask

  task automatic test_jitter();
    do_reset();
    evq.delete();
    for (int f = 0; f < 4; f++) send_jitter_frame();
    scan();
    n_checks++; if (n_ev !== 156) $display("FAIL jitter_events: got %0d expected 156", n_ev); else begin n_pass++; $display("check jitter_events ok"); end
    n_checks++; if (n_frame_ev !== 3) $display("FAIL jitter_frames: got %0d expected 3", n_frame_ev); else begin n_pass++; $display("check jitter_frames ok"); end
    n_checks++; if (evq[fidx[1]].locked !== 1'b0) $display("FAIL jitter_lock_f2: got %0b expected 0", evq[fidx[1]].locked); else begin n_pass++; $display("check jitter_lock_f2 ok"); end
    n_checks++; if (evq[fidx[2]].locked !== 1'b1 || fidx[2] !== 117) $display("FAIL jitter_lock_f3: got locked %0b pos %0d expected 1 117", evq[fidx[2]].locked, fidx[2]); else begin n_pass++; $display("check jitter_lock_f3 ok"); end
    n_checks++; if (n_err_ev !== 0) $display("FAIL jitter_err: got %0d expected 0", n_err_ev); else begin n_pass++; $display("check jitter_err ok"); end
  endtask

  task automatic test_mid_reset();
    bit found;
    bit fr;
    for (int i = 0; i < 10; i++) pulse(8, 8);
    iVI = 1'b1;
    cyc(4);
    n_checks++; if (oPulse !== 1'b1 || oIdx !== 6'd10 || oLocked !== 1'b1) $display("FAIL midrst_pre: got pulse %0b idx %0d locked %0b expected 1 10 1", oPulse, oIdx, oLocked); else begin n_pass++; $display("check midrst_pre ok"); end
    rst = 1'b0;
    cyc(1);
    n_checks++; if (oPulse !== 1'b0) $display("FAIL midrst_pulse: got %0b expected 0", oPulse); else begin n_pass++; $display("check midrst_pulse ok"); end
    n_checks++; if (oIdx !== 6'd0) $display("FAIL midrst_idx: got %0d expected 0", oIdx); else begin n_pass++; $display("check midrst_idx ok"); end
    n_checks++; if (oLocked !== 1'b0 || oFrame !== 1'b0 || oErr !== 1'b0) $display("FAIL midrst_flags: got locked %0b frame %0b err %0b expected 0 0 0", oLocked, oFrame, oErr); else begin n_pass++; $display("check midrst_flags ok"); end
    rst = 1'b1;
    found = 1'b0;
    fr    = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cyc(1);
      if (oPulse) begin
        found = 1'b1;
        fr    = oFrame;
      end
    end
    n_checks++; if (found !== 1'b1) $display("FAIL midrst_repulse: got %0b expected 1", found); else begin n_pass++; $display("check midrst_repulse ok"); end
    n_checks++; if (fr !== 1'b0) $display("FAIL midrst_noframe: got %0b expected 0", fr); else begin n_pass++; $display("check midrst_noframe ok"); end
    cyc(4);
    iVI = 1'b0;
    cyc(8);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    iVI      = 1'b0;
    test_reset();
    test_clean();
    test_short_frame();
    test_overflow();
    test_idle();
    test_jitter();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
